// File: rtl/addr_mode_1_if.sv
// addr_mode_1_if
//   Bundles the operand-path signals of the ARM addressing-mode-1 shifter.
//   slave  : the shifter block (consumes instruction/operand inputs,
//            produces the registered shifter operand and carry).
//   master : whoever feeds the shifter (decode stage or testbench).
//   Signals:
//     IR              32  current instruction word
//     Rs_LSB           8  low byte of Rs (register-shift amount)
//     Rm_data         32  Rm operand value
//     is_DPI/is_DPIS/is_DPRS          data-processing family strobes
//     is_LSIO/is_LSHSBCO/is_LSHSBSO   load/store family strobes
//     is_BL                           branch family strobe
//     is_pass_thru                    force IR through unchanged
//     C                1  current CPSR carry flag
//     shifter_operand 32  registered ALU B operand
//     shifter_carry    1  registered shifter carry-out
interface addr_mode_1_if;
  logic [31:0] IR;
  logic [7:0]  Rs_LSB;
  logic [31:0] Rm_data;
  logic        is_DPI;
  logic        is_DPIS;
  logic        is_DPRS;
  logic        is_LSIO;
  logic        is_LSHSBCO;
  logic        is_LSHSBSO;
  logic        is_BL;
  logic        is_pass_thru;
  logic        C;
  logic [31:0] shifter_operand;
  logic        shifter_carry;

  modport slave (
    input  IR, Rs_LSB, Rm_data,
    input  is_DPI, is_DPIS, is_DPRS,
    input  is_LSIO, is_LSHSBCO, is_LSHSBSO,
    input  is_BL, is_pass_thru, C,
    output shifter_operand, shifter_carry
  );

  modport master (
    output IR, Rs_LSB, Rm_data,
    output is_DPI, is_DPIS, is_DPRS,
    output is_LSIO, is_LSHSBCO, is_LSHSBSO,
    output is_BL, is_pass_thru, C,
    input  shifter_operand, shifter_carry
  );
endinterface

// File: rtl/addr_mode_1.sv
// addr_mode_1
//   ARM addressing-mode-1 shifter operand generator. Selects and computes
//   the ALU B operand and shifter carry-out from the instruction word and
//   register operands, then registers them (one-cycle latency).
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-low reset (clears operand and carry)
//     bus  addr_mode_1_if.slave operand-path bundle
module addr_mode_1 (
  input  logic          clk,
  input  logic          rst,
  addr_mode_1_if.slave  bus
);

  // All helpers return {carry_out, value}; amount must be 0..31.
  // Padding the operand by one bit lets the last bit shifted out fall
  // into a fixed position, so the carry needs no variable index.
  function automatic logic [32:0] lsl_n(input logic [31:0] v, input logic [4:0] n);
    logic [32:0] t;
    t = {1'b0, v} << n;
    return t;
  endfunction

  function automatic logic [32:0] lsr_n(input logic [31:0] v, input logic [4:0] n);
    logic [32:0] t;
    t = {v, 1'b0} >> n;
    return {t[0], t[32:1]};
  endfunction

  function automatic logic [32:0] asr_n(input logic [31:0] v, input logic [4:0] n);
    logic signed [32:0] t;
    t = $signed({v, 1'b0}) >>> n;
    return {t[0], t[32:1]};
  endfunction

  // Rotate right; the carry is the last bit rotated out, which lands in bit 31.
  function automatic logic [32:0] ror_n(input logic [31:0] v, input logic [4:0] n);
    logic [63:0] t;
    t = {v, v} >> n;
    return {t[31], t[31:0]};
  endfunction

  logic [32:0] next_res;
  logic [31:0] operand_q;
  logic        carry_q;
  logic [4:0]  rot_amt;
  logic [32:0] rot_res;
  logic [4:0]  imm_sh;
  logic [7:0]  reg_sh;

  always_comb begin
    next_res = {bus.C, bus.Rm_data};
    rot_amt  = {bus.IR[11:8], 1'b0};
    rot_res  = ror_n({24'b0, bus.IR[7:0]}, rot_amt);
    imm_sh   = bus.IR[11:7];
    reg_sh   = bus.Rs_LSB;

    if (bus.is_pass_thru) begin
      next_res = {bus.C, bus.IR};
    end else if (bus.is_DPI) begin
      next_res = {(rot_amt == 5'd0) ? bus.C : rot_res[31], rot_res[31:0]};
    end else if (bus.is_DPIS) begin
      // A zero immediate amount encodes shift-by-32 for LSR/ASR and RRX for ROR.
      unique case (bus.IR[6:5])
        2'b00: next_res = (imm_sh == 5'd0) ? {bus.C, bus.Rm_data}
                                           : lsl_n(bus.Rm_data, imm_sh);
        2'b01: next_res = (imm_sh == 5'd0) ? {bus.Rm_data[31], 32'b0}
                                           : lsr_n(bus.Rm_data, imm_sh);
        2'b10: next_res = (imm_sh == 5'd0) ? {bus.Rm_data[31], {32{bus.Rm_data[31]}}}
                                           : asr_n(bus.Rm_data, imm_sh);
        default: next_res = (imm_sh == 5'd0) ? {bus.Rm_data[0], bus.C, bus.Rm_data[31:1]}
                                             : ror_n(bus.Rm_data, imm_sh);
      endcase
    end else if (bus.is_DPRS) begin
      if (reg_sh != 8'd0) begin
        unique case (bus.IR[6:5])
          2'b00: begin
            if (reg_sh[7:5] == 3'd0)  next_res = lsl_n(bus.Rm_data, reg_sh[4:0]);
            else if (reg_sh == 8'd32) next_res = {bus.Rm_data[0], 32'b0};
            else                      next_res = 33'b0;
          end
          2'b01: begin
            if (reg_sh[7:5] == 3'd0)  next_res = lsr_n(bus.Rm_data, reg_sh[4:0]);
            else if (reg_sh == 8'd32) next_res = {bus.Rm_data[31], 32'b0};
            else                      next_res = 33'b0;
          end
          2'b10: begin
            if (reg_sh[7:5] == 3'd0) next_res = asr_n(bus.Rm_data, reg_sh[4:0]);
            else                     next_res = {bus.Rm_data[31], {32{bus.Rm_data[31]}}};
          end
          default: begin
            // Multiples of 32 rotate back to Rm itself, carry is Rm[31].
            if (reg_sh[4:0] == 5'd0) next_res = {bus.Rm_data[31], bus.Rm_data};
            else                     next_res = ror_n(bus.Rm_data, reg_sh[4:0]);
          end
        endcase
      end
    end else if (bus.is_LSIO) begin
      next_res = {bus.C, 20'b0, bus.IR[11:0]};
    end else if (bus.is_LSHSBCO) begin
      next_res = {bus.C, 24'b0, bus.IR[11:8], bus.IR[3:0]};
    end else if (bus.is_LSHSBSO) begin
      next_res = {bus.C, bus.Rm_data};
    end else if (bus.is_BL) begin
      next_res = {bus.C, {6{bus.IR[23]}}, bus.IR[23:0], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      operand_q <= 32'h0;
      carry_q   <= 1'b0;
    end else begin
      operand_q <= next_res[31:0];
      carry_q   <= next_res[32];
    end
  end

  assign bus.shifter_operand = operand_q;
  assign bus.shifter_carry   = carry_q;

endmodule

// File: tb/tb_addr_mode_1.sv
// tb_addr_mode_1
//   Self-checking bench for addr_mode_1. Expected {carry, operand} values are
//   queued when stimulus is driven and compared when the registered output
//   appears one clock later. Random vectors are checked against a bit-serial
//   reference model.
module tb_addr_mode_1;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  addr_mode_1_if bus ();

  addr_mode_1 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [32:0] expQ[$];
  string       tagQ[$];

  // Strobe vector order, highest priority first:
  // [7] pass_thru [6] DPI [5] DPIS [4] DPRS [3] LSIO [2] LSHSBCO [1] LSHSBSO [0] BL
  logic [7:0]  stb;
  logic [31:0] ir;
  logic [7:0]  rs;
  logic [31:0] rm;
  logic        cin;

  // Bit-serial reference shifter: one position per iteration, carry is the
  // last bit pushed out. Returns {carry, value}.
  function automatic logic [32:0] doShift(input logic [1:0] ty, input int amt,
                                          input logic [31:0] v, input logic c);
    logic [31:0] x;
    logic        cy;
    x  = v;
    cy = c;
    for (int k = 0; k < amt; k++) begin
      case (ty)
        2'd0: begin cy = x[31]; x = {x[30:0], 1'b0}; end
        2'd1: begin cy = x[0];  x = {1'b0, x[31:1]}; end
        2'd2: begin cy = x[0];  x = {x[31], x[31:1]}; end
        default: begin cy = x[0]; x = {x[0], x[31:1]}; end
      endcase
    end
    return {cy, x};
  endfunction

  function automatic logic [32:0] model(input logic [7:0] s, input logic [31:0] i,
                                        input logic [7:0] r, input logic [31:0] m,
                                        input logic c);
    logic [32:0] res;
    int          amt;
    res = {c, m};
    if (s[7]) res = {c, i};
    else if (s[6]) begin
      res = doShift(2'd3, int'(i[11:8]) * 2, {24'b0, i[7:0]}, c);
      if (i[11:8] != 4'd0) res[32] = res[31];
    end else if (s[5]) begin
      amt = int'(i[11:7]);
      if (amt == 0 && i[6:5] == 2'd3) res = {m[0], c, m[31:1]};
      else begin
        if (amt == 0 && i[6:5] != 2'd0) amt = 32;
        res = doShift(i[6:5], amt, m, c);
      end
    end else if (s[4]) begin
      if (r == 8'd0) res = {c, m};
      else if (i[6:5] == 2'd3) begin
        if (r[4:0] == 5'd0) res = {m[31], m};
        else                res = doShift(2'd3, int'(r[4:0]), m, c);
      end else res = doShift(i[6:5], int'(r), m, c);
    end else if (s[3]) res = {c, 20'b0, i[11:0]};
    else if (s[2]) res = {c, 24'b0, i[11:8], i[3:0]};
    else if (s[1]) res = {c, m};
    else if (s[0]) res = {c, {6{i[23]}}, i[23:0], 2'b00};
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [32:0] observed,
                             input logic [32:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got carry=%b operand=%h, expected carry=%b operand=%h",
               tag, observed[32], observed[31:0], expected[32], expected[31:0]);
    end
  endtask

  task automatic driveBus();
    bus.is_pass_thru = stb[7];
    bus.is_DPI       = stb[6];
    bus.is_DPIS      = stb[5];
    bus.is_DPRS      = stb[4];
    bus.is_LSIO      = stb[3];
    bus.is_LSHSBCO   = stb[2];
    bus.is_LSHSBSO   = stb[1];
    bus.is_BL        = stb[0];
    bus.IR           = ir;
    bus.Rs_LSB       = rs;
    bus.Rm_data      = rm;
    bus.C            = cin;
  endtask

  // Drives the current vector, queues its expectation, and after the next
  // rising edge pops and compares against the registered output.
  task automatic applyStimulus(input string tag, input logic [32:0] expected);
    logic [32:0] e;
    string       t;
    driveBus();
    expQ.push_back(expected);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    t = tagQ.pop_front();
    checkOutput(t, {bus.shifter_carry, bus.shifter_operand}, e);
  endtask

  initial begin
    int sel;
    logic [7:0] top;
    assertCount = 0;
    failCount   = 0;
    rst = 1'b0;
    stb = 8'h80; ir = 32'hFFFF_FFFF; rs = 8'h00; rm = 32'h1234_5678; cin = 1'b1;
    #2;
    applyStimulus("reset", {1'b0, 32'h0});
    rst = 1'b1;

    stb = 8'h40; ir = 32'h0000_04FF; cin = 1'b0;
    applyStimulus("dpi_rot", {1'b1, 32'hFF00_0000});
    ir = 32'h0000_00AB; cin = 1'b1;
    applyStimulus("dpi_norot", {1'b1, 32'h0000_00AB});

    stb = 8'h20; rm = 32'h8000_0001; ir = 32'h0000_0060; cin = 1'b0;
    applyStimulus("dpis_rrx", {1'b1, 32'h4000_0000});
    ir = 32'h0000_0040;
    applyStimulus("dpis_asr32", {1'b1, 32'hFFFF_FFFF});

    stb = 8'h10; rm = 32'h0000_0003; ir = 32'h0000_0000; cin = 1'b0;
    rs = 8'd32;
    applyStimulus("dprs_lsl32", {1'b1, 32'h0});
    rs = 8'd33;
    applyStimulus("dprs_lsl33", {1'b0, 32'h0});
    rs = 8'd0; cin = 1'b1;
    applyStimulus("dprs_lsl0", {1'b1, 32'h0000_0003});

    stb = 8'h01; ir = 32'h00FF_FFFE; cin = 1'b0;
    applyStimulus("bl_neg", {1'b0, 32'hFFFF_FFF8});
    stb = 8'hC0; ir = 32'hE3A0_0001; cin = 1'b1;
    applyStimulus("prio_pass", {1'b1, 32'hE3A0_0001});
    stb = 8'h04; ir = 32'h0000_0A5C; cin = 1'b0;
    applyStimulus("lshsbco", {1'b0, 32'h0000_00AC});

    stb = 8'h08; ir = 32'h0000_0123; cin = 1'b0;
    applyStimulus("lat_first", {1'b0, 32'h0000_0123});
    ir = 32'h0000_0456;
    driveBus();
    #3;
    checkOutput("lat_hold", {bus.shifter_carry, bus.shifter_operand}, {1'b0, 32'h0000_0123});
    applyStimulus("lat_next", {1'b0, 32'h0000_0456});

    rst = 1'b0; stb = 8'h40; ir = $urandom;
    applyStimulus("reset_mid", {1'b0, 32'h0});
    rst = 1'b1;

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 8);
      if (sel == 8) stb = 8'h00;
      else begin
        top = 8'h80 >> sel;
        stb = top | (8'($urandom) & (top - 8'd1));
      end
      ir  = $urandom;
      rm  = $urandom;
      cin = 1'($urandom);
      case ($urandom_range(0, 3))
        0: rs = 8'($urandom_range(0, 40));
        1: rs = 8'hFF;
        2: rs = {3'($urandom), 5'd0};
        default: rs = 8'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) ir[11:7] = 5'd0;
      applyStimulus("random", model(stb, ir, rs, rm, cin));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
